// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges execute and load results onto a single register-file
// write port, with one holding buffer per source and fair contention handling.
module writeback_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        ex_valid,
    input  logic        ex_wen,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        write_or_not,
    output logic [4:0]  writeaddr,
    output logic [31:0] writedata
);

    logic        ex_buf_valid;
    logic [4:0]  ex_buf_rd;
    logic [31:0] ex_buf_data;
    logic        ld_buf_valid;
    logic [4:0]  ld_buf_rd;
    logic [31:0] ld_buf_data;
    logic        last_grant_ld;

    logic        ex_in_ok;
    logic        ld_in_ok;
    logic        ex_cand;
    logic        ld_cand;
    logic [4:0]  ex_cand_rd;
    logic [31:0] ex_cand_data;
    logic [4:0]  ld_cand_rd;
    logic [31:0] ld_cand_data;
    logic        grant_ex;
    logic        grant_ld;
    logic        update_last;

    assign ex_ready = ~ex_buf_valid;
    assign ld_ready = ~ld_buf_valid;

    // Candidate selection and arbitration; entries that write nothing are dropped here
    always_comb begin
        ex_in_ok     = ex_valid & ~ex_buf_valid & ex_wen & (ex_rd != 5'd0) & ~flush_in;
        ld_in_ok     = ld_valid & ~ld_buf_valid & (ld_rd != 5'd0);
        ex_cand      = ~flush_in & (ex_buf_valid | ex_in_ok);
        ld_cand      = ld_buf_valid | ld_in_ok;
        ex_cand_rd   = ex_buf_valid ? ex_buf_rd   : ex_rd;
        ex_cand_data = ex_buf_valid ? ex_buf_data : ex_data;
        ld_cand_rd   = ld_buf_valid ? ld_buf_rd   : ld_rd;
        ld_cand_data = ld_buf_valid ? ld_buf_data : ld_data;
        grant_ex     = 1'b0;
        grant_ld     = 1'b0;
        update_last  = 1'b0;
        if (ex_cand && ld_cand) begin
            if (ex_cand_rd == ld_cand_rd) begin
                grant_ld = 1'b1;
            end else begin
                update_last = 1'b1;
                if (last_grant_ld) grant_ex = 1'b1;
                else               grant_ld = 1'b1;
            end
        end else begin
            grant_ex = ex_cand;
            grant_ld = ld_cand;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ex_buf_valid  <= 1'b0;
            ex_buf_rd     <= 5'd0;
            ex_buf_data   <= 32'd0;
            ld_buf_valid  <= 1'b0;
            ld_buf_rd     <= 5'd0;
            ld_buf_data   <= 32'd0;
            last_grant_ld <= 1'b0;
            write_or_not  <= 1'b0;
            writeaddr     <= 5'd0;
            writedata     <= 32'd0;
        end else begin
            if (update_last) last_grant_ld <= grant_ld;

            // A losing buffer simply keeps its contents
            if (flush_in) begin
                ex_buf_valid <= 1'b0;
            end else if (ex_buf_valid) begin
                if (grant_ex) ex_buf_valid <= 1'b0;
            end else if (ex_in_ok && !grant_ex) begin
                ex_buf_valid <= 1'b1;
                ex_buf_rd    <= ex_rd;
                ex_buf_data  <= ex_data;
            end

            if (ld_buf_valid) begin
                if (grant_ld) ld_buf_valid <= 1'b0;
            end else if (ld_in_ok && !grant_ld) begin
                ld_buf_valid <= 1'b1;
                ld_buf_rd    <= ld_rd;
                ld_buf_data  <= ld_data;
            end

            write_or_not <= grant_ex | grant_ld;
            if (grant_ld) begin
                writeaddr <= ld_cand_rd;
                writedata <= ld_cand_data;
            end else if (grant_ex) begin
                writeaddr <= ex_cand_rd;
                writedata <= ex_cand_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed traffic pushes expected writes,
// a negedge monitor pops and compares every register-file write the DUT issues.
module tb_writeback_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        ex_valid;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        write_or_not;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    writeback_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
        .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .write_or_not(write_or_not), .writeaddr(writeaddr), .writedata(writedata)
    );

    always #5 clk_in = ~clk_in;

    // Every write the DUT issues must match the oldest expected write
    always @(negedge clk_in) begin
        if (write_or_not) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, none expected",
                         writeaddr, writedata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({writeaddr, writedata} !== e) begin
                    errors++;
                    $display("[TB] FAIL write_order: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                             writeaddr, writedata, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clearInputs();
        flush_in = 1'b0;
        ex_valid = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    endtask

    // Drive one cycle of offers; sampled at the next rising edge, then inputs drop
    task automatic applyStimulus(input logic ev, input logic ew, input logic [4:0] er,
                                 input logic [31:0] ed, input logic lv,
                                 input logic [4:0] lr, input logic [31:0] ldat,
                                 input logic fl);
        ex_valid = ev; ex_wen = ew; ex_rd = er; ex_data = ed;
        ld_valid = lv; ld_rd = lr; ld_data = ldat; flush_in = fl;
        tick();
        clearInputs();
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    initial begin
        clearInputs();
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        checkOutput("reset_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("reset_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("reset_wen", 32'(write_or_not), 32'd0);
        checkOutput("reset_addr", 32'(writeaddr), 32'd0);
        checkOutput("reset_data", writedata, 32'd0);

        // Uncontended execute: write visible for exactly the next cycle
        expectWrite(5'd5, 32'h1234);
        applyStimulus(1, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0);
        checkOutput("uncont_wen", 32'(write_or_not), 32'd1);
        checkOutput("uncont_addr", 32'(writeaddr), 32'd5);
        tick();
        checkOutput("uncont_low", 32'(write_or_not), 32'd0);
        checkOutput("hold_addr", 32'(writeaddr), 32'd5);
        checkOutput("hold_data", writedata, 32'h1234);

        // First contest after reset: load wins, execute is buffered
        expectWrite(5'd4, 32'hB);
        expectWrite(5'd3, 32'hA);
        applyStimulus(1, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 0);
        checkOutput("contest_ex_ready", 32'(ex_ready), 32'd0);
        checkOutput("contest_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        checkOutput("contest_ex_drain", 32'(ex_ready), 32'd1);
        tick();

        // Repeat contest: execute wins this time
        expectWrite(5'd8, 32'hC);
        expectWrite(5'd9, 32'hD);
        applyStimulus(1, 1, 5'd8, 32'hC, 1, 5'd9, 32'hD, 0);
        checkOutput("repeat_ld_ready", 32'(ld_ready), 32'd0);
        tick(); tick();

        // Same rd: load first (last grant was execute here)
        expectWrite(5'd7, 32'd2);
        expectWrite(5'd7, 32'd1);
        applyStimulus(1, 1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 0);
        tick(); tick();
        // Contest to make last grant = load
        expectWrite(5'd11, 32'hF);
        expectWrite(5'd10, 32'hE);
        applyStimulus(1, 1, 5'd10, 32'hE, 1, 5'd11, 32'hF, 0);
        tick(); tick();
        // Same rd again: still load first, last grant untouched
        expectWrite(5'd7, 32'd4);
        expectWrite(5'd7, 32'd3);
        applyStimulus(1, 1, 5'd7, 32'd3, 1, 5'd7, 32'd4, 0);
        tick(); tick();
        // Last grant still load, so execute wins
        expectWrite(5'd12, 32'h12);
        expectWrite(5'd13, 32'h13);
        applyStimulus(1, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13, 0);
        tick(); tick();

        // Drops: rd==0, wen==0, load rd==0
        applyStimulus(1, 1, 5'd0, 32'h99, 0, 5'd0, 32'd0, 0);
        checkOutput("drop_rd0_ready", 32'(ex_ready), 32'd1);
        checkOutput("drop_rd0_wen", 32'(write_or_not), 32'd0);
        applyStimulus(1, 0, 5'd6, 32'h98, 0, 5'd0, 32'd0, 0);
        checkOutput("drop_wen0_ready", 32'(ex_ready), 32'd1);
        checkOutput("drop_wen0_wen", 32'(write_or_not), 32'd0);
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h97, 0);
        checkOutput("drop_ld_rd0_ready", 32'(ld_ready), 32'd1);
        checkOutput("drop_ld_rd0_wen", 32'(write_or_not), 32'd0);

        // Flush while execute is buffered behind a load
        expectWrite(5'd15, 32'h66);
        applyStimulus(1, 1, 5'd14, 32'h55, 1, 5'd15, 32'h66, 0);
        checkOutput("flush_pre_ex_ready", 32'(ex_ready), 32'd0);
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        checkOutput("flush_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("flush_wen", 32'(write_or_not), 32'd0);
        // Flush discards an execute input accepted the same cycle
        applyStimulus(1, 1, 5'd16, 32'h77, 0, 5'd0, 32'd0, 1);
        checkOutput("flush_input_wen", 32'(write_or_not), 32'd0);
        checkOutput("flush_input_ready", 32'(ex_ready), 32'd1);

        // Reset mid-operation: load buffered, write in flight, flush and offers present
        expectWrite(5'd17, 32'h1);
        applyStimulus(1, 1, 5'd17, 32'h1, 1, 5'd18, 32'h2, 0);
        checkOutput("pre_reset_ld_ready", 32'(ld_ready), 32'd0);
        rst_in = 1'b1;
        applyStimulus(1, 1, 5'd19, 32'h3, 1, 5'd20, 32'h4, 1);
        rst_in = 1'b0;
        checkOutput("midrst_wen", 32'(write_or_not), 32'd0);
        checkOutput("midrst_addr", 32'(writeaddr), 32'd0);
        checkOutput("midrst_data", writedata, 32'd0);
        checkOutput("midrst_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("midrst_ld_ready", 32'(ld_ready), 32'd1);
        tick(); tick();
        // After reset the load wins the first contest again
        expectWrite(5'd22, 32'h22);
        expectWrite(5'd21, 32'h21);
        applyStimulus(1, 1, 5'd21, 32'h21, 1, 5'd22, 32'h22, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick(); tick();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
